exc_ctrl: RTL and testbench
===========================

EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 Parameter EXC_VECTOR, default 32'hBFC00380, exception entry address.
REQ-002 Ports (name direction width meaning), clock and reset first; reset rst, synchronous, active-high; clock clk:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- valid_i  in  1  MEM-stage instruction valid
- pc_i  in  32  MEM-stage instruction PC
- delayslot_i  in  1  instruction is in a branch delay slot
- syscall_i, break_i, overflow_i, adel_i, ades_i, eret_i  in  1 each  raw exception/eret requests
- int_i  in  6  asynchronous hardware interrupt lines
- timer_int_i  in  1  timer interrupt from CP0
- status_i, cause_i, epc_i  in  32 each  current CP0 Status/Cause/EPC
- int_flag_o, syscall_flag_o, break_flag_o, overflow_flag_o, adel_flag_o, ades_flag_o, eret_flag_o  out  1 each  one-hot commit pulse to CP0
- delayslot_flag_o  out  1  delay-slot bit to CP0
- current_pc_addr_o  out  32  faulting PC to CP0
- hw_int_o  out  6  synchronized interrupt lines for Cause[15:10]
- flush_o  out  1  flush IF..MEM
- stall_o  out  1  freeze pipeline
- redirect_valid_o  out  1  fetch redirect strobe
- redirect_pc_o  out  32  redirect target

Function
REQ-003 int_i SHALL pass a 2-flop synchronizer; hw_int_o = second stage; bit 5 of the effective line SHALL be hw_int_o[5] OR timer_int_i.
REQ-004 Interrupt pending SHALL be: status_i[0]=1 AND status_i[1]=0 AND ((eff_hw & status_i[15:10]) != 0 OR (cause_i[9:8] & status_i[9:8]) != 0).
REQ-005 Events SHALL be sampled only in state IDLE with valid_i=1; otherwise ignored.
REQ-006 Priority, highest first: interrupt, adel, ades, overflow, syscall, break, eret; exactly one flag SHALL be selected.
REQ-007 FSM states IDLE, COMMIT, REDIRECT; IDLE->COMMIT on a selected event; COMMIT->REDIRECT unconditionally; REDIRECT->IDLE unconditionally.
REQ-008 On IDLE->COMMIT the block SHALL register selected kind, pc_i, delayslot_i.
REQ-009 In COMMIT (exactly 1 cycle): the selected *_flag_o =1, flush_o=1, stall_o=1, current_pc_addr_o=latched PC, delayslot_flag_o=latched bit.
REQ-010 In REDIRECT (exactly 1 cycle): all *_flag_o=0, flush_o=1, stall_o=1, redirect_valid_o=1, redirect_pc_o = epc_i if kind was eret, else EXC_VECTOR.
REQ-011 In IDLE: flags, flush_o, stall_o, redirect_valid_o SHALL be 0; redirect_pc_o and current_pc_addr_o hold last value.
REQ-012 Detect-to-CP0-pulse latency SHALL be 1 cycle; detect-to-redirect 2 cycles.
REQ-013 Simultaneous interrupt and synchronous exception on same instruction: interrupt SHALL win, exception discarded (re-raised on re-execution).
REQ-014 Events arriving during COMMIT/REDIRECT SHALL be dropped, not queued.
REQ-015 eret while interrupt pending and enabled: interrupt SHALL win per REQ-006.
REQ-016 delayslot_flag_o SHALL carry the raw bit; PC-4 adjustment is CP0's job.

Reset
REQ-017 rst SHALL force state IDLE, synchronizer flops, all 1-bit outputs, hw_int_o, redirect_pc_o, current_pc_addr_o to 0.
REQ-018 rst asserted in COMMIT or REDIRECT SHALL abort the sequence next edge; no further flag or redirect pulse.

Verification
REQ-019 syscall_i=1, valid_i=1, pc_i=0x80001000 at T -> T+1 syscall_flag_o=1, current_pc_addr_o=0x80001000, flush_o=1; T+2 redirect_valid_o=1, redirect_pc_o=0xBFC00380; T+3 idle.
REQ-020 eret_i=1, epc_i=0x80002004 -> T+1 eret_flag_o=1; T+2 redirect_pc_o=0x80002004.
REQ-021 status_i=0x0000FF01, int_i[2] rises -> 2 cycles later hw_int_o[2]=1; next valid instruction (with overflow_i=1) yields int_flag_o=1, overflow_flag_o=0.
REQ-022 status_i=0x0000FF03 (EXL=1), timer_int_i=1, valid_i=1 -> no flag, no flush, state IDLE.
REQ-023 adel_i and ades_i both 1 -> only adel_flag_o pulses; second break_i at T+1 dropped.
REQ-024 rst=1 during COMMIT -> next cycle all outputs 0, no redirect_valid_o.

Source files
------------

// File: rtl/exc_ctrl.sv
// exc_ctrl: MEM-stage exception/interrupt arbiter and commit sequencer.
// Picks one event per valid instruction, pulses its CP0 flag for one cycle
// (COMMIT), then issues a one-cycle fetch redirect (REDIRECT).
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   valid_i, pc_i, delayslot_i            MEM-stage instruction info
//   syscall_i..eret_i      raw exception / eret requests
//   int_i, timer_int_i     hardware interrupt lines, CP0 timer interrupt
//   status_i, cause_i, epc_i              current CP0 registers
//   *_flag_o               one-hot commit pulse to CP0
//   delayslot_flag_o, current_pc_addr_o   faulting instruction info to CP0
//   hw_int_o               synchronized interrupt lines for Cause[15:10]
//   flush_o, stall_o       pipeline flush / freeze
//   redirect_valid_o, redirect_pc_o       fetch redirect
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [31:0] pc_i,
  input  logic        delayslot_i,
  input  logic        syscall_i,
  input  logic        break_i,
  input  logic        overflow_i,
  input  logic        adel_i,
  input  logic        ades_i,
  input  logic        eret_i,
  input  logic [5:0]  int_i,
  input  logic        timer_int_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  output logic        int_flag_o,
  output logic        syscall_flag_o,
  output logic        break_flag_o,
  output logic        overflow_flag_o,
  output logic        adel_flag_o,
  output logic        ades_flag_o,
  output logic        eret_flag_o,
  output logic        delayslot_flag_o,
  output logic [31:0] current_pc_addr_o,
  output logic [5:0]  hw_int_o,
  output logic        flush_o,
  output logic        stall_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o
);

  localparam int unsigned FLAG_W = 7;
  // Flag vector bit positions, highest priority in the MSB.
  localparam int unsigned F_INT  = 6;
  localparam int unsigned F_ADEL = 5;
  localparam int unsigned F_ADES = 4;
  localparam int unsigned F_OVF  = 3;
  localparam int unsigned F_SYS  = 2;
  localparam int unsigned F_BRK  = 1;
  localparam int unsigned F_ERET = 0;

  typedef enum logic [1:0] {IDLE, COMMIT, REDIRECT} state_t;

  state_t              state;
  logic [5:0]          int_sync1;
  logic [5:0]          int_sync2;
  logic [FLAG_W-1:0]   flags_q;
  logic                eret_kind_q;
  logic [5:0]          eff_hw;
  logic                int_pending;
  logic [FLAG_W-1:0]   sel_flags;
  logic                event_hit;
  logic                unused_ok;

  // Status/Cause bits outside IE/EXL/IM and IP are not consulted here.
  assign unused_ok = ^{status_i[31:16], status_i[7:2], cause_i[31:10], cause_i[7:0]};

  // Timer interrupt shares hardware line 5; it is already synchronous to clk.
  assign eff_hw = {int_sync2[5] | timer_int_i, int_sync2[4:0]};

  assign int_pending = status_i[0] && !status_i[1] &&
                       (((eff_hw & status_i[15:10]) != 6'd0) ||
                        ((cause_i[9:8] & status_i[9:8]) != 2'd0));

  // Fixed-priority one-hot select.
  always_comb begin
    sel_flags = '0;
    if (int_pending)     sel_flags[F_INT]  = 1'b1;
    else if (adel_i)     sel_flags[F_ADEL] = 1'b1;
    else if (ades_i)     sel_flags[F_ADES] = 1'b1;
    else if (overflow_i) sel_flags[F_OVF]  = 1'b1;
    else if (syscall_i)  sel_flags[F_SYS]  = 1'b1;
    else if (break_i)    sel_flags[F_BRK]  = 1'b1;
    else if (eret_i)     sel_flags[F_ERET] = 1'b1;
  end

  assign event_hit = valid_i && (sel_flags != '0);

  // Sequencer with registered outputs; events outside IDLE are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      int_sync1         <= '0;
      int_sync2         <= '0;
      flags_q           <= '0;
      eret_kind_q       <= 1'b0;
      delayslot_flag_o  <= 1'b0;
      current_pc_addr_o <= '0;
      flush_o           <= 1'b0;
      stall_o           <= 1'b0;
      redirect_valid_o  <= 1'b0;
      redirect_pc_o     <= '0;
    end else begin
      int_sync1 <= int_i;
      int_sync2 <= int_sync1;
      case (state)
        IDLE: begin
          if (event_hit) begin
            state             <= COMMIT;
            flags_q           <= sel_flags;
            eret_kind_q       <= sel_flags[F_ERET];
            current_pc_addr_o <= pc_i;
            delayslot_flag_o  <= delayslot_i;
            flush_o           <= 1'b1;
            stall_o           <= 1'b1;
          end
        end
        COMMIT: begin
          state            <= REDIRECT;
          flags_q          <= '0;
          delayslot_flag_o <= 1'b0;
          redirect_valid_o <= 1'b1;
          redirect_pc_o    <= eret_kind_q ? epc_i : EXC_VECTOR;
        end
        REDIRECT: begin
          state            <= IDLE;
          flush_o          <= 1'b0;
          stall_o          <= 1'b0;
          redirect_valid_o <= 1'b0;
        end
        default: begin
          state            <= IDLE;
          flags_q          <= '0;
          delayslot_flag_o <= 1'b0;
          flush_o          <= 1'b0;
          stall_o          <= 1'b0;
          redirect_valid_o <= 1'b0;
        end
      endcase
    end
  end

  assign int_flag_o      = flags_q[F_INT];
  assign adel_flag_o     = flags_q[F_ADEL];
  assign ades_flag_o     = flags_q[F_ADES];
  assign overflow_flag_o = flags_q[F_OVF];
  assign syscall_flag_o  = flags_q[F_SYS];
  assign break_flag_o    = flags_q[F_BRK];
  assign eret_flag_o     = flags_q[F_ERET];
  assign hw_int_o        = int_sync2;

endmodule

// File: tb/tb_exc_ctrl.sv
module tb_exc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, delayslot_i;
  logic [31:0] pc_i;
  logic        syscall_i, break_i, overflow_i, adel_i, ades_i, eret_i;
  logic [5:0]  int_i;
  logic        timer_int_i;
  logic [31:0] status_i, cause_i, epc_i;
  logic        int_flag_o, syscall_flag_o, break_flag_o, overflow_flag_o;
  logic        adel_flag_o, ades_flag_o, eret_flag_o, delayslot_flag_o;
  logic [31:0] current_pc_addr_o;
  logic [5:0]  hw_int_o;
  logic        flush_o, stall_o, redirect_valid_o;
  logic [31:0] redirect_pc_o;
  logic [6:0]  flags;

  int checks = 0;
  int failures = 0;

  // {int, adel, ades, overflow, syscall, break, eret}
  localparam logic [6:0] F_NONE = 7'b0000000;
  localparam logic [6:0] F_INT  = 7'b1000000;
  localparam logic [6:0] F_ADEL = 7'b0100000;
  localparam logic [6:0] F_ADES = 7'b0010000;
  localparam logic [6:0] F_SYS  = 7'b0000100;
  localparam logic [6:0] F_ERET = 7'b0000001;

  assign flags = {int_flag_o, adel_flag_o, ades_flag_o, overflow_flag_o,
                  syscall_flag_o, break_flag_o, eret_flag_o};

  always #5 clk = ~clk;

  exc_ctrl dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .pc_i(pc_i), .delayslot_i(delayslot_i),
    .syscall_i(syscall_i), .break_i(break_i), .overflow_i(overflow_i),
    .adel_i(adel_i), .ades_i(ades_i), .eret_i(eret_i), .int_i(int_i),
    .timer_int_i(timer_int_i), .status_i(status_i), .cause_i(cause_i), .epc_i(epc_i),
    .int_flag_o(int_flag_o), .syscall_flag_o(syscall_flag_o), .break_flag_o(break_flag_o),
    .overflow_flag_o(overflow_flag_o), .adel_flag_o(adel_flag_o), .ades_flag_o(ades_flag_o),
    .eret_flag_o(eret_flag_o), .delayslot_flag_o(delayslot_flag_o),
    .current_pc_addr_o(current_pc_addr_o), .hw_int_o(hw_int_o), .flush_o(flush_o),
    .stall_o(stall_o), .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_events();
    valid_i = 0; syscall_i = 0; break_i = 0; overflow_i = 0;
    adel_i = 0; ades_i = 0; eret_i = 0; delayslot_i = 0;
  endtask

  task automatic test_reset();
    clear_events();
    rst = 1; pc_i = 32'h0; int_i = 6'h3F; timer_int_i = 0;
    status_i = 32'h0; cause_i = 32'h0; epc_i = 32'h0;
    step(); step();
    checks++;
    if ({flags, delayslot_flag_o, flush_o, stall_o, redirect_valid_o} !== 11'd0) begin
      failures++; $display("FAIL reset_bits got=%b want=0",
        {flags, delayslot_flag_o, flush_o, stall_o, redirect_valid_o});
    end
    checks++;
    if (hw_int_o !== 6'd0 || redirect_pc_o !== 32'd0 || current_pc_addr_o !== 32'd0) begin
      failures++; $display("FAIL reset_vectors hw=%h rpc=%h cpc=%h want 0",
        hw_int_o, redirect_pc_o, current_pc_addr_o);
    end
    int_i = 0;
    rst = 0;
    step(); step();
  endtask

  task automatic test_syscall();
    valid_i = 1; syscall_i = 1; pc_i = 32'h80001000;
    step();
    clear_events();
    checks++;
    if (flags !== F_SYS || flush_o !== 1 || stall_o !== 1 || redirect_valid_o !== 0) begin
      failures++; $display("FAIL sys_commit flags=%b fl=%b st=%b rv=%b want %b 1 1 0",
        flags, flush_o, stall_o, redirect_valid_o, F_SYS);
    end
    checks++;
    if (current_pc_addr_o !== 32'h80001000) begin
      failures++; $display("FAIL sys_pc got=%h want=80001000", current_pc_addr_o);
    end
    step();
    checks++;
    if (flags !== F_NONE || redirect_valid_o !== 1 || redirect_pc_o !== 32'hBFC00380 || flush_o !== 1) begin
      failures++; $display("FAIL sys_redirect flags=%b rv=%b rpc=%h fl=%b want 0 1 bfc00380 1",
        flags, redirect_valid_o, redirect_pc_o, flush_o);
    end
    step();
    checks++;
    if (flush_o !== 0 || stall_o !== 0 || redirect_valid_o !== 0 || redirect_pc_o !== 32'hBFC00380) begin
      failures++; $display("FAIL sys_idle fl=%b st=%b rv=%b rpc=%h want 0 0 0 bfc00380",
        flush_o, stall_o, redirect_valid_o, redirect_pc_o);
    end
  endtask

  task automatic test_eret();
    valid_i = 1; eret_i = 1; pc_i = 32'h80000200; epc_i = 32'h80002004;
    step();
    clear_events();
    checks++;
    if (flags !== F_ERET) begin
      failures++; $display("FAIL eret_flag got=%b want=%b", flags, F_ERET);
    end
    step();
    checks++;
    if (redirect_valid_o !== 1 || redirect_pc_o !== 32'h80002004) begin
      failures++; $display("FAIL eret_redirect rv=%b rpc=%h want 1 80002004", redirect_valid_o, redirect_pc_o);
    end
    step();
  endtask

  task automatic test_interrupt();
    status_i = 32'h0000FF01; int_i = 6'b000100;
    step();
    checks++;
    if (hw_int_o !== 6'd0) begin
      failures++; $display("FAIL sync_stage1 got=%b want=000000", hw_int_o);
    end
    step();
    checks++;
    if (hw_int_o !== 6'b000100) begin
      failures++; $display("FAIL sync_stage2 got=%b want=000100", hw_int_o);
    end
    valid_i = 1; overflow_i = 1; eret_i = 1; pc_i = 32'h80003000; delayslot_i = 1;
    step();
    clear_events();
    checks++;
    if (flags !== F_INT || delayslot_flag_o !== 1 || current_pc_addr_o !== 32'h80003000) begin
      failures++; $display("FAIL int_wins flags=%b ds=%b pc=%h want %b 1 80003000",
        flags, delayslot_flag_o, current_pc_addr_o, F_INT);
    end
    int_i = 0;
    step();
    checks++;
    if (redirect_pc_o !== 32'hBFC00380) begin
      failures++; $display("FAIL int_redirect got=%h want=bfc00380", redirect_pc_o);
    end
    step(); step();
    status_i = 32'h0;
  endtask

  task automatic test_exl_masks();
    status_i = 32'h0000FF03; timer_int_i = 1; valid_i = 1; pc_i = 32'h80004000;
    step();
    checks++;
    if (flags !== F_NONE || flush_o !== 0 || stall_o !== 0) begin
      failures++; $display("FAIL exl_mask flags=%b fl=%b st=%b want 0 0 0", flags, flush_o, stall_o);
    end
    step();
    checks++;
    if (flush_o !== 0 || redirect_valid_o !== 0) begin
      failures++; $display("FAIL exl_idle fl=%b rv=%b want 0 0", flush_o, redirect_valid_o);
    end
    // Only IM7 enabled: timer on line 5 must interrupt once EXL drops.
    status_i = 32'h00008001;
    step();
    clear_events();
    checks++;
    if (flags !== F_INT) begin
      failures++; $display("FAIL timer_int got=%b want=%b", flags, F_INT);
    end
    timer_int_i = 0; status_i = 32'h0;
    step(); step();
  endtask

  task automatic test_priority_drop();
    valid_i = 1; adel_i = 1; ades_i = 1; pc_i = 32'h80005000;
    step();
    clear_events();
    checks++;
    if (flags !== F_ADEL) begin
      failures++; $display("FAIL adel_over_ades got=%b want=%b", flags, F_ADEL);
    end
    valid_i = 1; break_i = 1; pc_i = 32'h80005004;
    step();
    clear_events();
    checks++;
    if (flags !== F_NONE || redirect_valid_o !== 1) begin
      failures++; $display("FAIL break_dropped flags=%b rv=%b want 0 1", flags, redirect_valid_o);
    end
    step();
    checks++;
    if (flags !== F_NONE || current_pc_addr_o !== 32'h80005000) begin
      failures++; $display("FAIL no_requeue flags=%b pc=%h want 0 80005000", flags, current_pc_addr_o);
    end
    valid_i = 1; ades_i = 1; overflow_i = 1; syscall_i = 1;
    step();
    clear_events();
    checks++;
    if (flags !== F_ADES) begin
      failures++; $display("FAIL ades_over_ovf got=%b want=%b", flags, F_ADES);
    end
    step(); step();
  endtask

  task automatic test_rst_abort();
    valid_i = 1; syscall_i = 1; pc_i = 32'h80006000;
    step();
    clear_events();
    checks++;
    if (flags !== F_SYS) begin
      failures++; $display("FAIL abort_commit got=%b want=%b", flags, F_SYS);
    end
    rst = 1;
    step();
    rst = 0;
    checks++;
    if ({flags, delayslot_flag_o, flush_o, stall_o, redirect_valid_o} !== 11'd0 ||
        current_pc_addr_o !== 32'd0 || redirect_pc_o !== 32'd0) begin
      failures++; $display("FAIL abort_reset bits=%b cpc=%h rpc=%h want 0",
        {flags, delayslot_flag_o, flush_o, stall_o, redirect_valid_o}, current_pc_addr_o, redirect_pc_o);
    end
    step();
    checks++;
    if (redirect_valid_o !== 0 || flags !== F_NONE || flush_o !== 0) begin
      failures++; $display("FAIL abort_after rv=%b flags=%b fl=%b want 0", redirect_valid_o, flags, flush_o);
    end
  endtask

  initial begin
    test_reset();
    test_syscall();
    test_eret();
    test_interrupt();
    test_exl_masks();
    test_priority_drop();
    test_rst_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
